// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared types for the boot-time instruction memory loader:
//            FSM state encoding, checksum width and header legality helper.
// Config   : LOADER_CHECKSUM_EN (consumed by imem_loader / checksum block)
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int CSUM_WIDTH = 8;

  typedef logic [CSUM_WIDTH-1:0] csum_t;

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  // A header word count is legal when it is non-zero and fits in imem.
  function automatic logic header_ok(input logic [15:0] count,
                                     input logic [16:0] max_words);
    return (count != 16'd0) && ({1'b0, count} <= max_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_checksum.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_checksum
// Purpose  : XOR accumulator over payload bytes with synchronous clear and
//            enable. Only built when LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef LOADER_CHECKSUM_EN
module imem_loader_checksum
  import imem_loader_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  clear,
  input  logic  enable,
  input  csum_t data,
  output csum_t sum
);

  // Running XOR of every enabled byte since the last clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum ^ data;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Boot-time writer for instruction memory. Accepts a
//            length-prefixed byte stream (count_hi, count_lo, 4*count bytes)
//            and writes it to imem from byte address 0, holding the CPU
//            until the image is complete.
// Config   : LOADER_CHECKSUM_EN - adds a trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 2**(ADDR_WIDTH-2)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  state_t                state;
  state_t                next_state;
  logic [7:0]            hdr_hi;
  // One bit wider than the address so a full image (4*MAX_WORDS) never wraps.
  logic [ADDR_WIDTH:0]   counter;
  logic [ADDR_WIDTH:0]   total;
  logic                  beat;
  logic                  last_byte;
  logic [15:0]           count_w;

  assign rx_ready  = (state == HDR_HI) || (state == HDR_LO) ||
                     (state == PAYLOAD) || (state == CHECK);
  assign beat      = rx_valid && rx_ready;
  assign last_byte = (counter == total - 1'b1);
  assign count_w   = {hdr_hi, rx_data};

`ifdef LOADER_CHECKSUM_EN
  csum_t sum;

  imem_loader_checksum u_checksum (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   ((state == HDR_LO) && beat),
    .enable  ((state == PAYLOAD) && beat),
    .data    (rx_data),
    .sum     (sum)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HDR_HI;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; DONE and ERROR are absorbing until reset.
  always_comb begin
    next_state = state;
    case (state)
      HDR_HI:  if (beat) next_state = HDR_LO;
      HDR_LO:  if (beat) next_state = header_ok(count_w, 17'(MAX_WORDS)) ? PAYLOAD : ERROR;
      PAYLOAD: begin
        if (beat && last_byte) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end
      end
      CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (beat) next_state = (rx_data == sum) ? DONE : ERROR;
`else
        // Unreachable without the checksum; fail safe with the CPU held.
        next_state = ERROR;
`endif
      end
      DONE:    next_state = DONE;
      ERROR:   next_state = ERROR;
      default: next_state = ERROR;
    endcase
  end

  // Header latch, image length and payload byte counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_hi  <= '0;
      total   <= '0;
      counter <= '0;
    end else if (beat) begin
      if (state == HDR_HI) begin
        hdr_hi <= rx_data;
      end else if (state == HDR_LO) begin
        total   <= {count_w[ADDR_WIDTH-2:0], 2'b00};
        counter <= '0;
      end else if (state == PAYLOAD) begin
        counter <= counter + 1'b1;
      end
    end
  end

  // Registered outputs: one-cycle write latency, release after the last write retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      mem_we     <= beat && (state == PAYLOAD);
      if (beat && (state == PAYLOAD)) begin
        mem_addr  <= counter[ADDR_WIDTH-1:0];
        mem_wdata <= rx_data;
      end
      cpu_hold   <= (state != DONE);
      load_done  <= (state == DONE);
      load_error <= (state == ERROR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader: stream-level reference
//            model compared every cycle plus literal expectations.
// Config   : LOADER_CHECKSUM_EN enables the checksum scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW        = 10;
  localparam int MAXW      = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;
  logic [7:0] imem [0:1023];
  logic       wipe = 1'b0;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Bench-side imem storage fed by the DUT write port.
  always @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < 1024; i++) imem[i] <= 8'h00;
    end else if (reset_n && mem_we) begin
      imem[mem_addr] <= mem_wdata;
      n_wr = n_wr + 1;
    end
  end

  // Stream-level reference model: byte index within the stream decides meaning.
  int         m_n, m_count;
  bit         m_fin, m_bad;
  logic       m_we, m_done, m_err;
  logic [9:0] m_addr;
  logic [7:0] m_wdata, m_hi, m_xor;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n = 0; m_count = 0; m_fin = 0; m_bad = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_done = 0; m_err = 0; m_hi = 0; m_xor = 0;
    end else begin
      m_done = m_fin;
      m_err  = m_bad;
      m_we   = 0;
      if (rx_valid && !(m_fin || m_bad)) begin
        m_n++;
        if (m_n == 1) m_hi = rx_data;
        else if (m_n == 2) begin
          m_count = {m_hi, rx_data};
          if (m_count == 0 || m_count > MAXW) m_bad = 1;
        end else if (m_n <= 2 + 4*m_count) begin
          m_we = 1; m_addr = 10'(m_n - 3); m_wdata = rx_data;
          m_xor = m_xor ^ rx_data;
`ifndef LOADER_CHECKSUM_EN
          if (m_n == 2 + 4*m_count) m_fin = 1;
`endif
        end else begin
          if (rx_data == m_xor) m_fin = 1; else m_bad = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("rx_ready", rx_ready, !(m_fin || m_bad));
      chk("mem_we", mem_we, m_we);
      if (m_we) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("load_done", load_done, m_done);
      chk("load_error", load_error, m_err);
      chk("cpu_hold", cpu_hold, !m_done);
    end
  end

  task automatic send(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_checks++;
      $display("FAIL send_timeout: rx_ready stuck at 0, byte %0h", b);
    end
    @(posedge clk);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_error", load_error, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rx_ready", rx_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_image(input bit gaps);
    logic [7:0] img [8];
    img = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    send(8'h00); send(8'h02);
    for (int i = 0; i < 8; i++) begin
      send(img[i]);
      if (gaps) gap(1);
    end
  endtask

  task automatic clear_imem();
    @(negedge clk); wipe = 1'b1;
    @(negedge clk); wipe = 1'b0;
  endtask

  initial begin
    int n0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    chk("por_cpu_hold", cpu_hold, 1);
    chk("por_mem_we", mem_we, 0);
    clear_imem();
    @(negedge clk); reset_n = 1'b1;

    // Contiguous image.
    n0 = n_wr;
    send_image(1'b0);
    gap(2);
    chk("t1_writes", n_wr - n0, 8);
    chk("t1_word0", {imem[0], imem[1], imem[2], imem[3]}, 32'hA1B2C3D4);
    chk("t1_word1", {imem[4], imem[5], imem[6], imem[7]}, 32'hE5F60718);
    chk("t1_done", load_done, 1);
    chk("t1_hold", cpu_hold, 0);

    // Bytes offered after completion are refused.
    n0 = n_wr;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h55;
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    chk("t6_ready", rx_ready, 0);
    chk("t6_writes", n_wr - n0, 0);

    // Same image with a gap after every byte.
    do_reset();
    clear_imem();
    n0 = n_wr;
    send_image(1'b1);
    gap(2);
    chk("t2_writes", n_wr - n0, 8);
    chk("t2_word0", {imem[0], imem[1], imem[2], imem[3]}, 32'hA1B2C3D4);
    chk("t2_word1", {imem[4], imem[5], imem[6], imem[7]}, 32'hE5F60718);
    chk("t2_done", load_done, 1);

    // Zero-length header.
    do_reset();
    n0 = n_wr;
    send(8'h00); send(8'h00);
    @(negedge clk); rx_valid = 1'b0;
    chk("t3a_err_early", load_error, 0);
    @(negedge clk);
    chk("t3a_err", load_error, 1);
    chk("t3a_hold", cpu_hold, 1);
    chk("t3a_ready", rx_ready, 0);
    chk("t3a_writes", n_wr - n0, 0);

    // Oversize header: 257 words > 256.
    do_reset();
    n0 = n_wr;
    send(8'h01); send(8'h01);
    @(negedge clk); rx_valid = 1'b0;
    chk("t3b_err_early", load_error, 0);
    @(negedge clk);
    chk("t3b_err", load_error, 1);
    chk("t3b_hold", cpu_hold, 1);
    chk("t3b_writes", n_wr - n0, 0);

    // Reset in the middle of a load, then a full reload.
    do_reset();
    send(8'h00); send(8'h02); send(8'h11); send(8'h22); send(8'h33);
    do_reset();
    send_image(1'b0);
    gap(2);
    chk("t5_done", load_done, 1);
    chk("t5_word0", {imem[0], imem[1], imem[2], imem[3]}, 32'hA1B2C3D4);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum: 12^34^56^78 = 08.
    do_reset();
    send(8'h00); send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h08);
    gap(2);
    chk("t4a_done", load_done, 1);
    chk("t4a_err", load_error, 0);

    // Bad checksum: writes remain, CPU held.
    do_reset();
    clear_imem();
    send(8'h00); send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h09);
    gap(2);
    chk("t4b_err", load_error, 1);
    chk("t4b_hold", cpu_hold, 1);
    chk("t4b_word0", {imem[0], imem[1], imem[2], imem[3]}, 32'h12345678);
`endif

    gap(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
